// File: rtl/clkdiv_pkg.sv
`timescale 1ns/1ps
// clkdiv_pkg
// Shared constants and phase helpers for the divide-by-4.5 clock divider.
// The phase counter steps once per half-period of the source clock and
// wraps after DIV_HALF_CYCLES steps; the output is high for the first
// HIGH_HALF_CYCLES phases of each output period.
package clkdiv_pkg;

  localparam int DIV_HALF_CYCLES  = 9;
  localparam int HIGH_HALF_CYCLES = 5;
  localparam int PH_W             = 4;

  typedef logic [PH_W-1:0] phase_t;

  localparam phase_t PH_LAST = phase_t'(DIV_HALF_CYCLES - 1);
  // Idle "pre-0" code: outside the 0..8 counting range.
  localparam phase_t PH_IDLE = phase_t'((2 ** PH_W) - 1);

  // Each edge domain reloads its high flag every other half-cycle, so a flag
  // loaded on phase p covers phases p and p+1. Loading 1 for phases
  // 0..HIGH_HALF_CYCLES-2 in both domains tiles exactly phases
  // 0..HIGH_HALF_CYCLES-1 with the OR of the two flags, and the handover
  // between domains always overlaps, so the OR never glitches.
  localparam phase_t PH_FLAG_LAST = phase_t'(HIGH_HALF_CYCLES - 2);

  function automatic phase_t ph_inc(input phase_t ph);
    return (ph == PH_LAST) ? '0 : ph + 1'b1;
  endfunction

  // Rising-edge load: the first rising edge out of idle is phase 0.
  function automatic phase_t ph_next_rise(input phase_t ph_fall);
    return (ph_fall == PH_IDLE) ? '0 : ph_inc(ph_fall);
  endfunction

  // Falling-edge load: a falling edge never starts the count from idle.
  function automatic phase_t ph_next_fall(input phase_t ph_rise);
    return (ph_rise == PH_IDLE) ? PH_IDLE : ph_inc(ph_rise);
  endfunction

endpackage

// File: rtl/half_cycle_phase_counter.sv
`timescale 1ns/1ps
// half_cycle_phase_counter
// Half-cycle phase counter built from one rising-edge and one falling-edge
// register. Each register loads the successor of the other, so together
// they step the phase 0..8 on every source-clock edge. The phase that each
// register is about to load is exported so the consumer can register a
// decode of it on the same edge.
//
// ph value | meaning
// ---------+-------------------------------------------------------------
// IDLE     | pre-0: in or just out of reset, waiting for a rising edge
// 0..4     | output high half-cycles
// 5..8     | output low half-cycles
//
// Ports:
//   i_clk            source clock, both edges used
//   i_rst            asynchronous active-high reset (forces IDLE)
//   o_ph_rise_next   phase the rising-edge register loads at next posedge
//   o_ph_fall_next   phase the falling-edge register loads at next negedge
module half_cycle_phase_counter
  import clkdiv_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst,
  output phase_t o_ph_rise_next,
  output phase_t o_ph_fall_next
);

  phase_t r_ph_rise;
  phase_t r_ph_fall;

  // Cross-domain reads are half a period old, so there is a full half
  // period of settling between the two registers.
  assign o_ph_rise_next = ph_next_rise(r_ph_fall);
  assign o_ph_fall_next = ph_next_fall(r_ph_rise);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ph_rise <= PH_IDLE;
    end else begin
      r_ph_rise <= o_ph_rise_next;
    end
  end

  always_ff @(negedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ph_fall <= PH_IDLE;
    end else begin
      r_ph_fall <= o_ph_fall_next;
    end
  end

endmodule

// File: rtl/divide_by_4_5.sv
`timescale 1ns/1ps
// divide_by_4_5
// Fractional clock divider: output period is 9 half-periods of the source
// clock (4.5 periods), high for 5 half-periods and low for 4. Output rises
// one source period at most after reset release, always on a rising edge.
//
// Ports:
//   clockin   source clock, both edges used (50% duty for exact 4.5)
//   reset     asynchronous active-high reset; forces clockout low at once
//   clockout  divided clock, driven by one OR of two edge-domain flops
module divide_by_4_5
  import clkdiv_pkg::*;
(
  input  logic clockin,
  input  logic reset,
  output logic clockout
);

  phase_t w_ph_rise_next;
  phase_t w_ph_fall_next;
  logic   r_hi_rise;
  logic   r_hi_fall;

  half_cycle_phase_counter u_phase (
    .i_clk          (clockin),
    .i_rst          (reset),
    .o_ph_rise_next (w_ph_rise_next),
    .o_ph_fall_next (w_ph_fall_next)
  );

  // IDLE is above PH_FLAG_LAST, so both flags stay low until counting.
  always_ff @(posedge clockin or posedge reset) begin
    if (reset) begin
      r_hi_rise <= 1'b0;
    end else begin
      r_hi_rise <= (w_ph_rise_next <= PH_FLAG_LAST);
    end
  end

  always_ff @(negedge clockin or posedge reset) begin
    if (reset) begin
      r_hi_fall <= 1'b0;
    end else begin
      r_hi_fall <= (w_ph_fall_next <= PH_FLAG_LAST);
    end
  end

  assign clockout = r_hi_rise | r_hi_fall;

endmodule

// File: tb/tb_divide_by_4_5.sv
`timescale 1ns/100ps
module tb_divide_by_4_5;

  logic clockin;
  logic reset;
  logic clockout;

  divide_by_4_5 dut (
    .clockin  (clockin),
    .reset    (reset),
    .clockout (clockout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: output is a 45 ns periodic waveform, high for the
  // first 25 ns, starting at the first rising edge strictly after release.
  bit     model_rst     = 1'b1;
  bit     model_started = 1'b0;
  longint model_t0      = 0;
  int     epoch         = 0;

  realtime last_rise  = 0.0;
  bit      rise_valid = 1'b0;
  int      rise_epoch = -1;

  realtime lit_t [9] = '{24.5, 25.5, 49.5, 50.5, 69.5, 70.5, 94.5, 95.5, 115.5};
  bit      lit_v [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
  realtime lit2_t[6] = '{2084.5, 2085.5, 2109.5, 2110.5, 2129.5, 2130.5};
  bit      lit2_v[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial clockin = 1'b0;
  always #5 clockin = ~clockin;

  function automatic longint next_rise_after(input longint tr);
    longint t;
    t = 5;
    if (tr >= 5) t = ((tr - 5) / 10 + 1) * 10 + 5;
    return t;
  endfunction

  function automatic bit model_out(input longint k);
    if (model_rst || !model_started || k < model_t0) return 1'b0;
    return ((k - model_t0) % 45) < 25;
  endfunction

  task automatic chk_bit(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $realtime, got, exp);
    end
  endtask

  task automatic chk_time(input string name, input realtime got, input realtime exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0t ns expected %0t ns", name, $realtime, got, exp);
    end
  endtask

  // Reset is driven non-blocking so a release on a clock edge is seen by the
  // DUT after that edge has been processed with reset still high.
  task automatic set_reset(input bit v);
    reset <= v;
    epoch++;
    if (v) begin
      model_rst = 1'b1;
    end else begin
      model_rst     = 1'b0;
      model_started = 1'b1;
      model_t0      = next_rise_after(longint'($time));
    end
  endtask

  task automatic at_time(input realtime t);
    if (t > $realtime) #(t - $realtime);
  endtask

  // Per-nanosecond comparison against the model, sampled at half-ns points
  // so it never coincides with a clock edge or a reset change.
  initial begin
    #0.5;
    forever begin
      chk_bit("model", clockout, model_out(longint'($realtime - 0.5)));
      #1;
    end
  end

  // Edge-interval monitor: catches narrow glitches the sampler could miss.
  always @(clockout) begin
    if (clockout === 1'b1) begin
      if (rise_valid && rise_epoch == epoch)
        chk_time("rise_to_rise", $realtime - last_rise, 45.0);
      last_rise  = $realtime;
      rise_valid = 1'b1;
      rise_epoch = epoch;
    end else if (clockout === 1'b0 && reset === 1'b0 && rise_valid && rise_epoch == epoch) begin
      chk_time("high_time", $realtime - last_rise, 25.0);
    end
  end

  initial begin
    set_reset(1'b1);
    at_time(10.5);
    chk_bit("in_reset", clockout, 1'b0);
    at_time(20.0);
    set_reset(1'b0);
    for (int i = 0; i < 9; i++) begin
      at_time(lit_t[i]);
      chk_bit("first_edges", clockout, lit_v[i]);
    end

    // Reset in the middle of a low phase.
    at_time(2000.0);
    set_reset(1'b1);
    at_time(2020.0);
    set_reset(1'b0);
    at_time(2062.0);
    set_reset(1'b1);
    at_time(2062.5);
    chk_bit("reset_mid_low", clockout, 1'b0);
    at_time(2083.0);
    set_reset(1'b0);
    for (int i = 0; i < 6; i++) begin
      at_time(lit2_t[i]);
      chk_bit("restart_edges", clockout, lit2_v[i]);
    end

    // Reset in the middle of a high phase drops the output at once.
    at_time(2200.0);
    set_reset(1'b1);
    at_time(2220.0);
    set_reset(1'b0);
    at_time(2234.5);
    chk_bit("pre_async_high", clockout, 1'b1);
    at_time(2235.0);
    set_reset(1'b1);
    at_time(2235.2);
    chk_bit("async_fall", clockout, 1'b0);

    // Release exactly on a rising edge: that edge is ignored.
    at_time(2260.0);
    @(posedge clockin);
    set_reset(1'b0);
    at_time(2274.5);
    chk_bit("coincident_ignored", clockout, 1'b0);
    at_time(2275.5);
    chk_bit("coincident_first_rise", clockout, 1'b1);

    // Random reset pulses at arbitrary integer-ns times.
    at_time(2280.0);
    for (int i = 0; i < 20; i++) begin
      #($urandom_range(400, 50));
      set_reset(1'b1);
      #($urandom_range(60, 1));
      set_reset(1'b0);
    end
    #400;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
